// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder
//   Turns one timestep of hidden-layer spike bits into a stream of
//   address-event (AER) tokens: one event per set bit, in ascending
//   address order, followed by an end-of-timestep (EOT) token. A timestep
//   counter advances each time an EOT token is accepted.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
//   ready are both 1. A producer holds its payload steady while valid=1
//   and ready=0. Here aer_valid/aer_addr/aer_eot are decoded only from
//   registers, so they stay put during any downstream stall.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   spk_vec    spike bits for one timestep, bit i = neuron i
//   spk_valid  spk_vec holds a timestep
//   spk_ready  encoder is idle and will capture spk_vec
//   aer_addr   neuron index of the presented event (0 for EOT)
//   aer_eot    presented event is the end-of-timestep token
//   aer_valid  an event is presented
//   aer_ready  downstream accepts the presented event
//   ts_cnt     number of completed timesteps, wraps modulo 2^TS_W
//   fsm_state  current FSM state (0 IDLE, 1 SCAN, 2 EOT) for observation

module spike_aer_encoder #(
    parameter int NUM_NEURONS = 64,
    parameter int ADDR_W      = 6,
    parameter int TS_W        = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_NEURONS-1:0] spk_vec,
    input  logic                   spk_valid,
    output logic                   spk_ready,
    output logic [ADDR_W-1:0]      aer_addr,
    output logic                   aer_eot,
    output logic                   aer_valid,
    input  logic                   aer_ready,
    output logic [TS_W-1:0]        ts_cnt,
    output logic [1:0]             fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EOT  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [NUM_NEURONS-1:0] pending;
    logic [NUM_NEURONS-1:0] pending_nxt;
    logic [TS_W-1:0]        ts_nxt;
    logic [ADDR_W-1:0]      low_idx;
    logic                   vec_fire;
    logic                   aer_fire;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pending <= '0;
            ts_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            ts_cnt  <= ts_nxt;
        end
    end

    // Lowest set bit of pending. Scanning from the top down lets the last
    // (lowest) match win without a break.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = ADDR_W'(i);
            end
        end
    end

    assign vec_fire = spk_valid && (state == IDLE);
    assign aer_fire = aer_ready && (state != IDLE);

    // Next-state logic
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        ts_nxt      = ts_cnt;
        case (state)
            IDLE: begin
                if (vec_fire) begin
                    pending_nxt = spk_vec;
                    state_nxt   = (spk_vec != '0) ? SCAN : EOT;
                end
            end
            SCAN: begin
                if (aer_fire) begin
                    // x & (x-1) drops exactly the lowest set bit, which is
                    // the one currently presented.
                    pending_nxt = pending & (pending - NUM_NEURONS'(1));
                    if (pending_nxt == '0) begin
                        state_nxt = EOT;
                    end
                end
            end
            EOT: begin
                if (aer_fire) begin
                    ts_nxt    = ts_cnt + TS_W'(1);
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                pending_nxt = '0;
            end
        endcase
    end

    // Output decode, registers only
    always_comb begin
        spk_ready = (state == IDLE);
        aer_valid = (state == SCAN) || (state == EOT);
        aer_eot   = (state == EOT);
        aer_addr  = (state == SCAN) ? low_idx : '0;
        fsm_state = state;
    end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Bench for spike_aer_encoder: directed table of vectors, hand-written
// reset/wrap sequences, and a randomized phase. A monitor checks every
// cycle against an event queue built from the spec rules (bits in
// ascending order, then one EOT token).

module tb_spike_aer_encoder;

    localparam int NN   = 64;
    localparam int AW   = 6;
    localparam int TSW  = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NN-1:0] spk_vec;
    logic          spk_valid;
    logic          spk_ready;
    logic [AW-1:0] aer_addr;
    logic          aer_eot;
    logic          aer_valid;
    logic          aer_ready;
    logic [TSW-1:0] ts_cnt;
    logic [1:0]    fsm_state;

    spike_aer_encoder #(.NUM_NEURONS(NN), .ADDR_W(AW), .TS_W(TSW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .spk_vec   (spk_vec),
        .spk_valid (spk_valid),
        .spk_ready (spk_ready),
        .aer_addr  (aer_addr),
        .aer_eot   (aer_eot),
        .aer_valid (aer_valid),
        .aer_ready (aer_ready),
        .ts_cnt    (ts_cnt),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Each entry is {eot, addr}.
    logic [AW:0]    exp_q[$];
    logic [TSW-1:0] exp_ts = '0;
    logic           prev_stall = 1'b0;
    logic [AW:0]    prev_ev = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            exp_ts     = '0;
            prev_stall = 1'b0;
            chk("rst_aer_valid", 64'(aer_valid), 64'd0);
            chk("rst_aer_eot", 64'(aer_eot), 64'd0);
            chk("rst_aer_addr", 64'(aer_addr), 64'd0);
            chk("rst_ts_cnt", 64'(ts_cnt), 64'd0);
            chk("rst_spk_ready", 64'(spk_ready), 64'd1);
        end else begin
            automatic bit idle_now = (exp_q.size() == 0);
            chk("aer_valid", 64'(aer_valid), 64'(!idle_now));
            chk("spk_ready", 64'(spk_ready), 64'(idle_now));
            chk("ts_cnt", 64'(ts_cnt), 64'(exp_ts));
            if (prev_stall)
                chk("stall_hold", 64'({aer_valid, aer_eot, aer_addr}), 64'({1'b1, prev_ev}));
            if (aer_valid && !idle_now) begin
                chk("event", 64'({aer_eot, aer_addr}), 64'(exp_q[0]));
                if (aer_ready) begin
                    if (exp_q[0][AW]) exp_ts = exp_ts + 1'b1;
                    void'(exp_q.pop_front());
                end
            end
            prev_stall = aer_valid && !aer_ready;
            prev_ev    = {aer_eot, aer_addr};
            // Capture only when the model itself is idle.
            if (spk_valid && idle_now) begin
                for (int i = 0; i < NN; i++)
                    if (spk_vec[i]) exp_q.push_back({1'b0, AW'(i)});
                exp_q.push_back({1'b1, {AW{1'b0}}});
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [NN-1:0] rand_vec();
        logic [NN-1:0] v;
        case ($urandom_range(0, 3))
            0: v = '0;
            1: begin v = '0; v[$urandom_range(0, NN-1)] = 1'b1; end
            2: v = {$urandom, $urandom};
            default: v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Entered and left at posedge+1. Stalls aer_ready for stall_len cycles
    // while the event with index stall_at is presented.
    task automatic run_vec(input logic [NN-1:0] vec, input int stall_at, input int stall_len,
                           output int n_ev, output int n_busy, output logic [AW-1:0] first_a);
        int stalled = 0;
        bit done = 0;
        n_ev = 0; n_busy = 0; first_a = '0;
        spk_vec   = vec;
        spk_valid = 1'b1;
        aer_ready = !(stall_at == 0 && stall_len > 0);
        @(posedge clk); #1;
        spk_valid = 1'b0;
        spk_vec   = rand_vec();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!aer_valid) begin done = 1; break; end
            n_busy++;
            if (aer_ready) begin
                if (n_ev == 0) first_a = aer_addr;
                n_ev++;
            end else begin
                stalled++;
            end
            @(posedge clk); #1;
            aer_ready = !(n_ev == stall_at && stalled < stall_len);
            spk_vec   = rand_vec();
        end
        if (!done) chk("run_vec_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        aer_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        spk_valid = 1'b1;            // must not capture while in reset
        spk_vec   = rand_vec() | 64'h1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold_valid", 64'(aer_valid), 64'd0);
        chk("reset_hold_ts", 64'(ts_cnt), 64'd0);
        spk_valid = 1'b0;
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 64'(spk_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [NN-1:0] vec;
        int            stall_at;
        int            stall_len;
        int            exp_ev;
        int            exp_busy;
        logic [AW-1:0] exp_first;
    } vec_rec_t;

    vec_rec_t tbl[5];

    initial begin
        int ev, busy;
        logic [AW-1:0] fa;

        reset_n = 1'b0; spk_vec = '0; spk_valid = 1'b0; aer_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        tbl[0] = '{64'h25, -1, 0, 4, 4, 6'd0};
        tbl[1] = '{64'h0, -1, 0, 1, 1, 6'd0};
        tbl[2] = '{(64'h1 << 63) | 64'h8, 0, 5, 3, 8, 6'd3};
        tbl[3] = '{{NN{1'b1}}, -1, 0, 65, 65, 6'd0};
        tbl[4] = '{64'h1 << 63, 1, 3, 2, 5, 6'd63};

        for (int t = 0; t < 5; t++) begin
            run_vec(tbl[t].vec, tbl[t].stall_at, tbl[t].stall_len, ev, busy, fa);
            chk($sformatf("tbl%0d_events", t), 64'(ev), 64'(tbl[t].exp_ev));
            chk($sformatf("tbl%0d_busy", t), 64'(busy), 64'(tbl[t].exp_busy));
            chk($sformatf("tbl%0d_first", t), 64'(fa), 64'(tbl[t].exp_first));
        end
        chk("ts_after_table", 64'(ts_cnt), 64'd5);

        // Reset during the third event of 0x0F.
        spk_vec = 64'h0F; spk_valid = 1'b1; aer_ready = 1'b1;
        @(posedge clk); #1;
        spk_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_third_addr", 64'(aer_addr), 64'd2);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(aer_valid), 64'd0);
        chk("mid_rst_ts", 64'(ts_cnt), 64'd0);
        chk("mid_rst_eot", 64'(aer_eot), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        run_vec(64'h30, -1, 0, ev, busy, fa);
        chk("post_rst_first", 64'(fa), 64'd4);
        chk("post_rst_events", 64'(ev), 64'd3);
        chk("post_rst_ts", 64'(ts_cnt), 64'd1);

        // Timestep counter wrap with 17 empty vectors.
        do_reset();
        for (int n = 1; n <= 17; n++) begin
            run_vec('0, -1, 0, ev, busy, fa);
            if (n == 15) chk("wrap_15", 64'(ts_cnt), 64'd15);
            if (n == 16) chk("wrap_16", 64'(ts_cnt), 64'd0);
            if (n == 17) chk("wrap_17", 64'(ts_cnt), 64'd1);
        end

        // Randomized traffic with random backpressure and input noise.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            spk_valid = ($urandom_range(0, 3) != 0);
            spk_vec   = rand_vec();
            aer_ready = ($urandom_range(0, 9) < 7);
        end

        // Drain
        spk_valid = 1'b0;
        aer_ready = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_idle", 64'(fsm_state), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/spike_aer_encoder.md
SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 64: width of the spike vector from one hidden layer.
REQ-002 SHALL have parameter ADDR_W, default 6: address width, with 2^ADDR_W >= NUM_NEURONS.
REQ-003 SHALL have parameter TS_W, default 16: width of the timestep counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 spk_vec  input  NUM_NEURONS  one timestep of hidden-neuron spk bits; bit i is neuron i.
REQ-007 spk_valid  input  1  spk_vec holds a valid timestep.
REQ-008 spk_ready  output  1  encoder accepts a new vector.
REQ-009 aer_addr  output  ADDR_W  index of the spiking neuron for the current event.
REQ-010 aer_eot  output  1  current event is the end-of-timestep token.
REQ-011 aer_valid  output  1  an event is presented on aer_addr/aer_eot.
REQ-012 aer_ready  input  1  downstream accepts the event.
REQ-013 ts_cnt  output  TS_W  count of completed timesteps.

Function
REQ-014 SHALL implement an FSM with states IDLE, SCAN and EOT.
REQ-015 SHALL drive spk_ready = 1 exactly when the state is IDLE.
REQ-016 SHALL capture on a vector handshake (spk_valid & spk_ready at a rising edge): pending <= spk_vec, then go to SCAN if spk_vec != 0, else to EOT.
REQ-017 SHALL drive aer_valid = 1 exactly when the state is SCAN or EOT, so aer_valid rises in the cycle after capture.
REQ-018 In SCAN, SHALL drive aer_addr = index of the lowest set bit of pending and aer_eot = 0.
REQ-019 In EOT, SHALL drive aer_addr = 0 and aer_eot = 1.
REQ-020 In SCAN, on an event handshake (aer_valid & aer_ready) SHALL clear the presented bit of pending; if no bits remain, SHALL go to EOT, else stay in SCAN.
REQ-021 In EOT, on an event handshake SHALL increment ts_cnt (modulo 2^TS_W, 2^TS_W-1 wraps to 0) and go to IDLE.
REQ-022 SHALL present the next event in the cycle after an accept, with no bubble cycles; a vector with k set bits therefore produces exactly k+1 events, in ascending address order.
REQ-023 SHALL hold aer_addr, aer_eot and aer_valid stable while aer_valid=1 and aer_ready=0, for any duration.
REQ-024 SHALL have no combinational path from any input to any output except spk_ready -> spk_valid-independent, i.e. all outputs are decoded from registers only.
REQ-025 SHALL ignore spk_vec and spk_valid outside IDLE; spk_vec changes during SCAN or EOT SHALL NOT affect the events emitted.
REQ-026 SHALL treat spk_vec bits at or above NUM_NEURONS as nonexistent, so only addresses 0..NUM_NEURONS-1 are ever emitted.
REQ-027 SHALL permit a new capture in the cycle after the EOT accept (IDLE reached); minimum vector period is k+2 cycles.

Reset
REQ-028 While reset_n=0, SHALL hold: state=IDLE, pending=0, ts_cnt=0, aer_valid=0, aer_eot=0, aer_addr=0.
REQ-029 While reset_n=0, SHALL perform no capture regardless of spk_valid.
REQ-030 Reset asserted mid-SCAN or mid-EOT SHALL abort the timestep without emitting its EOT token; ts_cnt SHALL read 0 after reset.
REQ-031 SHALL resume normal operation on the first rising edge after reset_n deasserts, with spk_ready=1 in that cycle.

Verification
REQ-032 Basic scan: spk_vec=0x...0000_0000_0000_0025 with aer_ready=1 -> events addr 0, 2, 5, then EOT on 4 consecutive cycles; ts_cnt 0->1.
REQ-033 Empty vector: spk_vec=0 -> one EOT event only, in the cycle after capture; ts_cnt increments by 1.
REQ-034 Backpressure: bits {3,63} with aer_ready low for 5 cycles on addr 3 -> addr 3 held stable for the whole stall, then 63, then EOT; no loss or duplication.
REQ-035 Full vector: all 64 bits set with aer_ready=1 -> addr 0..63 back-to-back, then EOT; spk_ready=0 for 65 cycles.
REQ-036 Reset mid-operation: reset_n pulsed low during the 3rd event -> aer_valid=0 immediately, ts_cnt=0, next vector handled from address 0 of its own bits.
REQ-037 Wrap: TS_W=4, 17 empty vectors -> ts_cnt reads 15 then 0 then 1.
